// File: rtl/mem_stage.sv
// Beta pipeline memory stage: registers execute results, runs LD/LDR/ST over a req/ack
// data-memory handshake and feeds writeback. MEM_ALIGN_CHECK_EN traps misaligned memory ops.
module mem_stage #(
    parameter logic [31:0] NOP_INST = 32'h83FF_F800,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_mem_next,
    input  logic [31:0]       ir_mem_next,
    input  logic [31:0]       y_mem_next,
    input  logic [31:0]       st_mem_next,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_misalign,
    output logic [31:0]       pc_wb_next,
    output logic [31:0]       ir_wb_next,
    output logic [31:0]       y_wb_next
);

    localparam logic [5:0] OPCODE_LD  = 6'h18;
    localparam logic [5:0] OPCODE_ST  = 6'h19;
    localparam logic [5:0] OPCODE_LDR = 6'h1F;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_mem;
    logic [31:0] ir_mem;
    logic [31:0] y_mem;
    logic [31:0] st_mem;
    logic [31:0] ld_data;
    logic        trap_q;
    logic        trap_d;
    logic        next_is_mem;
    logic        cur_is_st;
    logic        cur_is_load;

    assign next_is_mem = (ir_mem_next[31:26] == OPCODE_LD) ||
                         (ir_mem_next[31:26] == OPCODE_ST) ||
                         (ir_mem_next[31:26] == OPCODE_LDR);
    assign cur_is_st   = (ir_mem[31:26] == OPCODE_ST);
    assign cur_is_load = (ir_mem[31:26] == OPCODE_LD) || (ir_mem[31:26] == OPCODE_LDR);
    assign mem_stall   = (state_q == REQ);
    assign mem_misalign = trap_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign trap_d = next_is_mem && (y_mem_next[1:0] != 2'b00);
`else
    assign trap_d = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any non-stalled edge re-decodes the incoming instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ: begin
                if (dmem_ack) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = (next_is_mem && !trap_d) ? REQ : IDLE;
            end
        endcase
    end

    // Stage registers and captured load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_mem  <= 32'h0;
            ir_mem  <= NOP_INST;
            y_mem   <= 32'h0;
            st_mem  <= 32'h0;
            ld_data <= 32'h0;
            trap_q  <= 1'b0;
        end else begin
            if (!mem_stall) begin
                pc_mem <= pc_mem_next;
                ir_mem <= ir_mem_next;
                y_mem  <= y_mem_next;
                st_mem <= st_mem_next;
                trap_q <= trap_d;
            end
            if (mem_stall && dmem_ack) begin
                ld_data <= dmem_rdata;
            end
        end
    end

    // Memory port and writeback view; REQ and trapped ops present a bubble
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = cur_is_st;
        dmem_addr  = {y_mem[ADDR_W-1:2], 2'b00};
        dmem_wdata = st_mem;
        pc_wb_next = pc_mem;
        ir_wb_next = ir_mem;
        y_wb_next  = y_mem;
        case (state_q)
            REQ: begin
                dmem_req   = 1'b1;
                ir_wb_next = NOP_INST;
                y_wb_next  = 32'h0;
            end
            DONE: begin
                if (cur_is_load) begin
                    y_wb_next = ld_data;
                end
            end
            default: begin
                if (trap_q) begin
                    ir_wb_next = NOP_INST;
                    y_wb_next  = 32'h0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, hand-written reset-mid-access sequence,
// and randomized traffic against a transaction-level reference model.
module tb_mem_stage;

    localparam logic [31:0] NOP   = 32'h83FF_F800;
    localparam logic [31:0] I_ADD = 32'h8020_0800;
    localparam logic [31:0] I_LD  = 32'h6020_0000;
    localparam logic [31:0] I_ST  = 32'h6420_0000;
    localparam logic [31:0] I_LDR = 32'h7C20_0000;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack, mem_misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_mem_next (pc_mem_next),
        .ir_mem_next (ir_mem_next),
        .y_mem_next  (y_mem_next),
        .st_mem_next (st_mem_next),
        .mem_stall   (mem_stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .mem_misalign(mem_misalign),
        .pc_wb_next  (pc_wb_next),
        .ir_wb_next  (ir_wb_next),
        .y_wb_next   (y_wb_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, ir, y, st, rdata;
        logic        ack;
        logic        e_stall, e_req, e_we, e_mis;
        logic [31:0] e_addr, e_wdata, e_pc, e_ir, e_y;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc, ir, y, st;
    } op_t;

    vec_t tbl[$];

    // Reference model: the op held in the stage and where its access stands
    op_t         m_op;
    bit          m_busy, m_completed, m_mis;
    logic [31:0] m_data;

    function automatic vec_t mk(input logic [31:0] pc, ir, y, st, input logic ack,
                                input logic [31:0] rdata, input logic stall, req, we,
                                input logic [31:0] addr, wdata, input logic mis,
                                input logic [31:0] epc, eir, ey);
        vec_t r;
        r.pc = pc; r.ir = ir; r.y = y; r.st = st; r.ack = ack; r.rdata = rdata;
        r.e_stall = stall; r.e_req = req; r.e_we = we; r.e_addr = addr; r.e_wdata = wdata;
        r.e_mis = mis; r.e_pc = epc; r.e_ir = eir; r.e_y = ey;
        return r;
    endfunction

    function automatic bit is_mem(input logic [31:0] ir);
        logic [5:0] o;
        o = ir[31:26];
        return (o == 6'h18) || (o == 6'h19) || (o == 6'h1F);
    endfunction

    function automatic bit is_load(input logic [31:0] ir);
        logic [5:0] o;
        o = ir[31:26];
        return (o == 6'h18) || (o == 6'h1F);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, ir, y, st, input logic ack,
                         input logic [31:0] rdata);
        pc_mem_next = pc; ir_mem_next = ir; y_mem_next = y; st_mem_next = st;
        dmem_ack = ack; dmem_rdata = rdata;
    endtask

    task automatic model_reset();
        m_op = '{pc: 32'h0, ir: NOP, y: 32'h0, st: 32'h0};
        m_busy = 1'b0; m_completed = 1'b0; m_mis = 1'b0; m_data = 32'h0;
    endtask

    task automatic model_step(input op_t nxt, input logic ack, input logic [31:0] rdata);
        if (!m_busy) begin
            m_op        = nxt;
            m_mis       = ALIGN_EN && is_mem(nxt.ir) && (nxt.y[1:0] != 2'b00);
            m_busy      = is_mem(nxt.ir) && !m_mis;
            m_completed = 1'b0;
        end else if (ack) begin
            m_data      = rdata;
            m_busy      = 1'b0;
            m_completed = 1'b1;
        end
    endtask

    task automatic check_model(input int cyc);
        bit          bubble;
        logic [31:0] ey;
        bubble = m_busy || m_mis;
        ey = bubble ? 32'h0 : ((m_completed && is_load(m_op.ir)) ? m_data : m_op.y);
        check($sformatf("rnd%0d stall", cyc), 32'(mem_stall), 32'(m_busy));
        check($sformatf("rnd%0d req", cyc), 32'(dmem_req), 32'(m_busy));
        check($sformatf("rnd%0d misalign", cyc), 32'(mem_misalign), 32'(m_mis));
        check($sformatf("rnd%0d pc_wb", cyc), pc_wb_next, m_op.pc);
        check($sformatf("rnd%0d ir_wb", cyc), ir_wb_next, bubble ? NOP : m_op.ir);
        check($sformatf("rnd%0d y_wb", cyc), y_wb_next, ey);
        if (m_busy) begin
            check($sformatf("rnd%0d we", cyc), 32'(dmem_we), 32'(m_op.ir[31:26] == 6'h19));
            check($sformatf("rnd%0d addr", cyc), dmem_addr, m_op.y & 32'hFFFF_FFFC);
            check($sformatf("rnd%0d wdata", cyc), dmem_wdata, m_op.st);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " stall"}, 32'(mem_stall), 32'h0);
        check({tag, " req"}, 32'(dmem_req), 32'h0);
        check({tag, " misalign"}, 32'(mem_misalign), 32'h0);
        check({tag, " pc_wb"}, pc_wb_next, 32'h0);
        check({tag, " ir_wb"}, ir_wb_next, NOP);
        check({tag, " y_wb"}, y_wb_next, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(32'h0, I_ADD, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        op_t         nop_in;
        logic [31:0] rir, ry;
        logic        rack;

        // Directed sequence; each row's expectation holds after the following edge
        tbl.push_back(mk(32'h10, I_ADD, 32'd3,    32'h0,    1'b0, 32'h0,        0, 0, 0, 32'h0,   32'h0,    0, 32'h10, I_ADD, 32'd3));
        tbl.push_back(mk(32'h14, I_LD,  32'h100,  32'hAAAA, 1'b1, 32'h0BAD,     1, 1, 0, 32'h100, 32'hAAAA, 0, 32'h14, NOP,   32'h0));
        tbl.push_back(mk(32'h14, I_LD,  32'h100,  32'hAAAA, 1'b0, 32'h0,        1, 1, 0, 32'h100, 32'hAAAA, 0, 32'h14, NOP,   32'h0));
        tbl.push_back(mk(32'h14, I_LD,  32'h100,  32'hAAAA, 1'b0, 32'h0,        1, 1, 0, 32'h100, 32'hAAAA, 0, 32'h14, NOP,   32'h0));
        tbl.push_back(mk(32'h14, I_LD,  32'h100,  32'hAAAA, 1'b1, 32'hDEADBEEF, 0, 0, 0, 32'h0,   32'h0,    0, 32'h14, I_LD,  32'hDEADBEEF));
        tbl.push_back(mk(32'h18, I_ST,  32'h204,  32'h12345678, 1'b1, 32'h0BAD, 1, 1, 1, 32'h204, 32'h12345678, 0, 32'h18, NOP, 32'h0));
        tbl.push_back(mk(32'h18, I_ST,  32'h204,  32'h12345678, 1'b1, 32'h5555, 0, 0, 0, 32'h0,   32'h0,    0, 32'h18, I_ST,  32'h204));
        tbl.push_back(mk(32'h1C, I_LDR, 32'h300,  32'h0,    1'b0, 32'h0,        1, 1, 0, 32'h300, 32'h0,    0, 32'h1C, NOP,   32'h0));
        tbl.push_back(mk(32'h1C, I_LDR, 32'h300,  32'h0,    1'b1, 32'h11112222, 0, 0, 0, 32'h0,   32'h0,    0, 32'h1C, I_LDR, 32'h11112222));
        tbl.push_back(mk(32'h20, I_LD,  32'h308,  32'h0,    1'b1, 32'h0BAD,     1, 1, 0, 32'h308, 32'h0,    0, 32'h20, NOP,   32'h0));
        tbl.push_back(mk(32'h20, I_LD,  32'h308,  32'h0,    1'b1, 32'h33334444, 0, 0, 0, 32'h0,   32'h0,    0, 32'h20, I_LD,  32'h33334444));
        tbl.push_back(mk(32'h24, I_ADD, 32'd9,    32'h0,    1'b0, 32'h0,        0, 0, 0, 32'h0,   32'h0,    0, 32'h24, I_ADD, 32'd9));
        tbl.push_back(mk(32'h28, I_LD,  32'h102,  32'hBB,   1'b0, 32'h0,        !ALIGN_EN, !ALIGN_EN, 0, 32'h100, 32'hBB, ALIGN_EN, 32'h28, NOP, 32'h0));
        if (ALIGN_EN)
            tbl.push_back(mk(32'h2C, I_ADD, 32'd5, 32'h0, 1'b0, 32'h0,          0, 0, 0, 32'h0,   32'h0,    0, 32'h2C, I_ADD, 32'd5));
        else
            tbl.push_back(mk(32'h28, I_LD, 32'h102, 32'hBB, 1'b1, 32'hCAFEF00D, 0, 0, 0, 32'h0,   32'h0,    0, 32'h28, I_LD,  32'hCAFEF00D));
        tbl.push_back(mk(32'h30, I_ADD, 32'd6,    32'h0,    1'b0, 32'h0,        0, 0, 0, 32'h0,   32'h0,    0, 32'h30, I_ADD, 32'd6));

        rst_n = 1'b0;
        drive(32'h0, I_ADD, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].pc, tbl[i].ir, tbl[i].y, tbl[i].st, tbl[i].ack, tbl[i].rdata);
            @(negedge clk);
            check($sformatf("vec%0d stall", i), 32'(mem_stall), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d req", i), 32'(dmem_req), 32'(tbl[i].e_req));
            check($sformatf("vec%0d misalign", i), 32'(mem_misalign), 32'(tbl[i].e_mis));
            check($sformatf("vec%0d pc_wb", i), pc_wb_next, tbl[i].e_pc);
            check($sformatf("vec%0d ir_wb", i), ir_wb_next, tbl[i].e_ir);
            check($sformatf("vec%0d y_wb", i), y_wb_next, tbl[i].e_y);
            if (tbl[i].e_req) begin
                check($sformatf("vec%0d we", i), 32'(dmem_we), 32'(tbl[i].e_we));
                check($sformatf("vec%0d addr", i), dmem_addr, tbl[i].e_addr);
                check($sformatf("vec%0d wdata", i), dmem_wdata, tbl[i].e_wdata);
            end
        end

        // Reset in the middle of an unacknowledged load
        drive(32'h40, I_LD, 32'h40, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("midreq req before reset", 32'(dmem_req), 32'h1);
        check("midreq addr before reset", dmem_addr, 32'h40);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreq in reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midreq ir_wb after release", ir_wb_next, NOP);
        drive(32'h50, I_ADD, 32'd11, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("midreq resume ir_wb", ir_wb_next, I_ADD);
        check("midreq resume y_wb", y_wb_next, 32'd11);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 4))
                0: rir = I_LD | ($urandom & 32'h03FF_FFFF);
                1: rir = I_ST | ($urandom & 32'h03FF_FFFF);
                2: rir = I_LDR | ($urandom & 32'h03FF_FFFF);
                3: rir = I_ADD;
                default: rir = $urandom;
            endcase
            ry   = $urandom;
            if ($urandom_range(0, 1) == 0) ry = ry & 32'hFFFF_FFFC;
            rack = ($urandom_range(0, 2) == 0);
            nop_in = '{pc: $urandom, ir: rir, y: ry, st: $urandom};
            drive(nop_in.pc, nop_in.ir, nop_in.y, nop_in.st, rack, $urandom);
            model_step(nop_in, rack, dmem_rdata);
            @(negedge clk);
            check_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
